// File: rtl/div_pkg.sv
// Shared types and constants for the divider sequencer.
package div_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_FIXUP,
    ST_SIGN,
    ST_DONE
  } state_t;

  // Bits needed to hold an iteration count of 0..w.
  function automatic int unsigned cnt_width(int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_sequencer_if.sv
// Control/status bundle between the divider sequencer and its datapath/host.
interface divider_sequencer_if import div_pkg::*; #(
  parameter int unsigned WIDTH = 32
) ();

  localparam int unsigned CW = cnt_width(WIDTH);

  logic          start;
  logic          abort;
  logic          signed_mode;
  logic          dividend_sign;
  logic          divisor_sign;
  logic          divisor_zero;
  logic          rem_msb;
  logic          alu_msb;
  logic          load;
  logic          add;
  logic          sub;
  logic          shift_quotient;
  logic          q_bit;
  logic          fix_remainder;
  logic          negate_quotient;
  logic          negate_remainder;
  logic          busy;
  logic          ready;
  logic          div_by_zero;
  logic [CW-1:0] count;

  modport master (
    output start, abort, signed_mode, dividend_sign, divisor_sign,
           divisor_zero, rem_msb, alu_msb,
    input  load, add, sub, shift_quotient, q_bit, fix_remainder,
           negate_quotient, negate_remainder, busy, ready, div_by_zero, count
  );

  modport slave (
    input  start, abort, signed_mode, dividend_sign, divisor_sign,
           divisor_zero, rem_msb, alu_msb,
    output load, add, sub, shift_quotient, q_bit, fix_remainder,
           negate_quotient, negate_remainder, busy, ready, div_by_zero, count
  );

endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter: clear has priority over increment; tc flags the last iteration.
module div_iter_counter import div_pkg::*; #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // High while the iteration that brings the count to WIDTH is running.
  assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/divider_sequencer.sv
// Control sequencer for a non-restoring WIDTH-bit divider with optional sign correction.
module divider_sequencer import div_pkg::*; #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  divider_sequencer_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("divider_sequencer: WIDTH out of range");
  end

  state_t        state;
  state_t        state_nxt;
  logic          cnt_clr_c;
  logic          cnt_inc_c;
  logic          cnt_tc;
  logic [CW-1:0] cnt;
  logic          sm_q;
  logic          ds_q;
  logic          vs_q;
  logic          dz_q;

  div_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clr_c),
    .inc     (cnt_inc_c),
    .count   (cnt),
    .tc      (cnt_tc)
  );

  assign bus.count = cnt;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand sign/mode and divide-by-zero captured while loading.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sm_q <= 1'b0;
      ds_q <= 1'b0;
      vs_q <= 1'b0;
      dz_q <= 1'b0;
    end else if (state == ST_LOAD) begin
      sm_q <= bus.signed_mode;
      ds_q <= bus.dividend_sign;
      vs_q <= bus.divisor_sign;
      dz_q <= bus.divisor_zero;
    end
  end

  // Next-state and output decode; only add/sub/q_bit/fix_remainder look at datapath flags.
  always_comb begin
    state_nxt            = state;
    cnt_clr_c            = 1'b0;
    cnt_inc_c            = 1'b0;
    bus.load             = 1'b0;
    bus.add              = 1'b0;
    bus.sub              = 1'b0;
    bus.shift_quotient   = 1'b0;
    bus.q_bit            = 1'b0;
    bus.fix_remainder    = 1'b0;
    bus.negate_quotient  = 1'b0;
    bus.negate_remainder = 1'b0;
    bus.busy             = 1'b0;
    bus.ready            = 1'b0;
    bus.div_by_zero      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_LOAD;
          cnt_clr_c = 1'b1;
        end
      end
      ST_LOAD: begin
        bus.load  = 1'b1;
        bus.busy  = 1'b1;
        state_nxt = bus.divisor_zero ? ST_DONE : ST_ITER;
      end
      ST_ITER: begin
        bus.busy           = 1'b1;
        bus.shift_quotient = 1'b1;
        bus.q_bit          = ~bus.alu_msb;
        cnt_inc_c          = 1'b1;
        // The first step always subtracts; later steps follow the remainder sign.
        if (cnt == '0) begin
          bus.sub = 1'b1;
        end else begin
          bus.sub = ~bus.rem_msb;
          bus.add = bus.rem_msb;
        end
        if (cnt_tc) begin
          state_nxt = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        bus.busy          = 1'b1;
        bus.fix_remainder = bus.rem_msb;
        state_nxt         = ST_SIGN;
      end
      ST_SIGN: begin
        bus.busy             = 1'b1;
        bus.negate_quotient  = SIGNED_EN & sm_q & (ds_q ^ vs_q);
        bus.negate_remainder = SIGNED_EN & sm_q & ds_q;
        state_nxt            = ST_DONE;
      end
      ST_DONE: begin
        bus.ready       = 1'b1;
        bus.div_by_zero = dz_q;
        if (bus.start) begin
          state_nxt = ST_LOAD;
          cnt_clr_c = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (bus.abort) begin
      state_nxt = ST_IDLE;
      cnt_clr_c = 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Randomised bench for divider_sequencer (WIDTH=4 and WIDTH=32) against a schedule-based model.
module tb_divider_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, signed_mode = 1'b0;
  logic dividend_sign = 1'b0, divisor_sign = 1'b0, divisor_zero = 1'b0;
  logic rem_msb = 1'b0, alu_msb = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  divider_sequencer_if #(.WIDTH(4))  b4 ();
  divider_sequencer_if #(.WIDTH(32)) b32 ();

  assign b4.start = start;                  assign b32.start = start;
  assign b4.abort = abort;                  assign b32.abort = abort;
  assign b4.signed_mode = signed_mode;      assign b32.signed_mode = signed_mode;
  assign b4.dividend_sign = dividend_sign;  assign b32.dividend_sign = dividend_sign;
  assign b4.divisor_sign = divisor_sign;    assign b32.divisor_sign = divisor_sign;
  assign b4.divisor_zero = divisor_zero;    assign b32.divisor_zero = divisor_zero;
  assign b4.rem_msb = rem_msb;              assign b32.rem_msb = rem_msb;
  assign b4.alu_msb = alu_msb;              assign b32.alu_msb = alu_msb;

  divider_sequencer #(.WIDTH(4), .SIGNED_EN(1'b1)) u4 (
    .clock(clock), .reset_n(reset_n), .bus(b4)
  );
  divider_sequencer u32 (
    .clock(clock), .reset_n(reset_n), .bus(b32)
  );

  // Output order: load add sub shift q fix negq negr busy ready dbz
  logic [10:0] ov0, ov1;
  int oc0, oc1;
  assign ov0 = {b4.load, b4.add, b4.sub, b4.shift_quotient, b4.q_bit, b4.fix_remainder,
                b4.negate_quotient, b4.negate_remainder, b4.busy, b4.ready, b4.div_by_zero};
  assign ov1 = {b32.load, b32.add, b32.sub, b32.shift_quotient, b32.q_bit, b32.fix_remainder,
                b32.negate_quotient, b32.negate_remainder, b32.busy, b32.ready, b32.div_by_zero};
  assign oc0 = int'(b4.count);
  assign oc1 = int'(b32.count);

  // Model: an operation is a timeline of offsets since the accepted start.
  // k=1 load, k=2..W+1 iterations, k=W+2 remainder fix, k=W+3 sign fix, then done.
  int mode [2];
  int k    [2];
  bit lsm  [2];
  bit lds  [2];
  bit lvs  [2];
  bit ldz  [2];

  function automatic int wd(int i);
    return (i == 0) ? 4 : 32;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mode[i] <= M_IDLE; k[i] <= 0;
        lsm[i] <= 1'b0; lds[i] <= 1'b0; lvs[i] <= 1'b0; ldz[i] <= 1'b0;
      end else if (abort) begin
        mode[i] <= M_IDLE;
      end else if (mode[i] == M_RUN) begin
        if (k[i] == 1) begin
          lsm[i] <= signed_mode; lds[i] <= dividend_sign;
          lvs[i] <= divisor_sign; ldz[i] <= divisor_zero;
          if (divisor_zero) mode[i] <= M_DONE;
          else k[i] <= 2;
        end else if (k[i] == wd(i) + 3) begin
          mode[i] <= M_DONE;
        end else begin
          k[i] <= k[i] + 1;
        end
      end else if (start) begin
        mode[i] <= M_RUN;
        k[i] <= 1;
      end
    end
  end

  function automatic logic [10:0] exp_vec(int i);
    logic ld, ad, sb, sh, q, fx, nq, nr, bs, rd, dz;
    int w;
    w = wd(i);
    {ld, ad, sb, sh, q, fx, nq, nr, bs, rd, dz} = '0;
    if (mode[i] == M_RUN) begin
      bs = 1'b1;
      if (k[i] == 1) begin
        ld = 1'b1;
      end else if (k[i] <= w + 1) begin
        sh = 1'b1;
        q  = ~alu_msb;
        if (k[i] == 2) begin
          sb = 1'b1;
        end else begin
          sb = ~rem_msb;
          ad = rem_msb;
        end
      end else if (k[i] == w + 2) begin
        fx = rem_msb;
      end else begin
        nq = lsm[i] & (lds[i] ^ lvs[i]);
        nr = lsm[i] & lds[i];
      end
    end else if (mode[i] == M_DONE) begin
      rd = 1'b1;
      dz = ldz[i];
    end
    return {ld, ad, sb, sh, q, fx, nq, nr, bs, rd, dz};
  endfunction

  function automatic int exp_cnt(int i);
    if (mode[i] == M_RUN) begin
      if (k[i] == 1) return 0;
      if (k[i] <= wd(i) + 1) return k[i] - 2;
      return wd(i);
    end
    if (mode[i] == M_DONE) return ldz[i] ? 0 : wd(i);
    return 0;
  endfunction

  // Per-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic [10:0] got_v, want_v;
      int got_c, want_c;
      got_v  = (i == 0) ? ov0 : ov1;
      got_c  = (i == 0) ? oc0 : oc1;
      want_v = exp_vec(i);
      want_c = exp_cnt(i);
      tests++;
      if (got_v !== want_v) begin
        fails++;
        $display("FAIL outputs w=%0d t=%0t: got %b want %b", wd(i), $time, got_v, want_v);
      end
      tests++;
      if (got_c != want_c) begin
        fails++;
        $display("FAIL count w=%0d t=%0t: got %0d want %0d", wd(i), $time, got_c, want_c);
      end
    end
  end

  task automatic chk(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Drive a WIDTH=4 operation up to its sign-correction cycle; signs change after capture.
  task automatic run_to_sign(input logic sm, input logic ds, input logic vs);
    signed_mode = sm; dividend_sign = ds; divisor_sign = vs;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    signed_mode = ~sm; dividend_sign = ~ds; divisor_sign = ~vs;
    repeat (5) tick();
    #1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(b4.busy), 0);
    chk("rst_count", oc1, 0);
    chk("rst_ready", int'(b32.ready), 0);
    reset_n = 1'b1;

    // Basic WIDTH=4 timeline with add/sub/q_bit/fix decisions.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_c1", int'(b4.load), 1);
    tick();
    rem_msb = 1'b1; alu_msb = 1'b0; #1;
    chk("it1_sub", int'(b4.sub), 1);
    chk("it1_add", int'(b4.add), 0);
    tick();
    #1;
    chk("it2_add", int'(b4.add), 1);
    chk("it2_sub", int'(b4.sub), 0);
    chk("it2_q", int'(b4.q_bit), 1);
    chk("it2_cnt", oc0, 1);
    tick();
    rem_msb = 1'b0; alu_msb = 1'b1; #1;
    chk("it3_sub", int'(b4.sub), 1);
    chk("it3_q", int'(b4.q_bit), 0);
    tick();
    chk("it4_shift", int'(b4.shift_quotient), 1);
    tick();
    rem_msb = 1'b1; #1;
    chk("fix_rem", int'(b4.fix_remainder), 1);
    chk("fix_shift", int'(b4.shift_quotient), 0);
    chk("fix_cnt", oc0, 4);
    tick();
    rem_msb = 1'b0; alu_msb = 1'b0;
    chk("sign_ready", int'(b4.ready), 0);
    tick();
    chk("done_ready", int'(b4.ready), 1);
    chk("done_cnt", oc0, 4);
    chk("done_busy", int'(b4.busy), 0);

    // Sign correction.
    run_to_sign(1'b1, 1'b1, 1'b0);
    chk("neg_q_10", int'(b4.negate_quotient), 1);
    chk("neg_r_10", int'(b4.negate_remainder), 1);
    tick();
    run_to_sign(1'b1, 1'b1, 1'b1);
    chk("neg_q_11", int'(b4.negate_quotient), 0);
    chk("neg_r_11", int'(b4.negate_remainder), 1);
    tick();
    run_to_sign(1'b0, 1'b1, 1'b0);
    chk("neg_q_uns", int'(b4.negate_quotient), 0);
    chk("neg_r_uns", int'(b4.negate_remainder), 0);
    tick();
    signed_mode = 1'b0; dividend_sign = 1'b0; divisor_sign = 1'b0;

    // Divide by zero, then a restart from DONE.
    divisor_zero = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dz_load", int'(b4.load), 1);
    tick();
    divisor_zero = 1'b0;
    chk("dz_ready", int'(b4.ready), 1);
    chk("dz_flag", int'(b4.div_by_zero), 1);
    chk("dz_cnt", oc0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_dz", int'(b4.div_by_zero), 0);
    chk("restart_rdy", int'(b4.ready), 0);

    // Ignored start mid-operation, then abort in the third iteration.
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_cnt", oc0, 2);
    chk("ign_start_sh", int'(b4.shift_quotient), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(b4.busy), 0);
    chk("abort_ready", int'(b4.ready), 0);
    chk("abort_cnt", oc0, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_wins", int'(b4.busy), 0);

    // Reset between edges during iteration, then a full WIDTH=32 division.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("async_busy", int'(b32.busy), 0);
    chk("async_shift", int'(b32.shift_quotient), 0);
    chk("async_sub", int'(b32.sub), 0);
    chk("async_cnt", oc1, 0);
    tick();
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("w32_load", int'(b32.load), 1);
    repeat (34) tick();
    chk("w32_sign_rdy", int'(b32.ready), 0);
    tick();
    chk("w32_ready", int'(b32.ready), 1);
    chk("w32_cnt", oc1, 32);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      tick();
      start         = ($urandom_range(0, 3) == 0);
      abort         = ($urandom_range(0, 299) == 0);
      signed_mode   = 1'($urandom_range(0, 1));
      dividend_sign = 1'($urandom_range(0, 1));
      divisor_sign  = 1'($urandom_range(0, 1));
      divisor_zero  = ($urandom_range(0, 7) == 0);
      rem_msb       = 1'($urandom_range(0, 1));
      alu_msb       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
